// File: rtl/alu_share_arb.sv
// alu_share_arb: one shared combinational ALU time-multiplexed between the
// integer execute path (requester 0) and the address/branch-compare unit
// (requester 1). Round-robin grant, single registered response slot that is
// held until its owner accepts it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no result pending, busy=0, any granted request is accepted
// S_FULL  | result held in resp_s for 'owner', accept only on same-cycle drain
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_s,
    output logic             busy
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last, last_nxt;
    logic             load;
    logic [1:0]       grant;
    logic             drain;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [OP_W-1:0]  alu_op;
    logic [4:0]       shamt;

    // Round-robin grant: a tie goes to the requester that was not served last.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign drain      = (state == S_FULL) && resp_ready[owner];
    assign can_accept = (state == S_EMPTY) || drain;
    // Gated by rst_n so req_ready reads 00 while reset is held, even with valids up.
    assign req_ready  = (rst_n && can_accept) ? grant : 2'b00;
    assign xfer       = |(req_valid & req_ready);

    // Operand mux: the granted requester drives the shared ALU.
    always_comb begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
        if (grant[1]) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    assign shamt = alu_b[4:0];

    // Shared ALU; undefined op codes quietly produce zero.
    always_comb begin
        alu_y = '0;
        case (alu_op)
            4'b0000: alu_y = alu_a + alu_b;
            4'b1000: alu_y = alu_a - alu_b;
            4'b0001: alu_y = alu_a << shamt;
            4'b0010: alu_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'b0011: alu_y = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            4'b0100: alu_y = alu_a ^ alu_b;
            4'b0101: alu_y = alu_a >> shamt;
            4'b1101: alu_y = WIDTH'($signed(alu_a) >>> shamt);
            4'b0110: alu_y = alu_a | alu_b;
            4'b0111: alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    // Slot next-state: a drain and a new accept in the same cycle reload back-to-back.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        load      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (xfer) begin
                    state_nxt = S_FULL;
                    load      = 1'b1;
                end
            end
            S_FULL: begin
                if (drain) begin
                    if (xfer) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (load) begin
            owner_nxt = grant[1];
            last_nxt  = grant[1];
        end
    end

    // Slot, owner, rr pointer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_EMPTY;
            owner  <= 1'b0;
            last   <= 1'b1;
            resp_s <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            if (load) begin
                resp_s <= alu_y;
            end
        end
    end

    assign busy       = (state == S_FULL);
    assign resp_valid = (state == S_FULL) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Time-shares one combinational 32-bit ALU instance between two requesters: requester 0 is the integer execute path, requester 1 is the address/branch-compare unit.
- Requests arrive on valid/ready handshakes and are arbitrated round-robin.
- The chosen operands/op drive the internal ALU; the result is registered into a single response slot tagged with the owner.
- The slot is held until the owner accepts it.

Parameters:
- WIDTH, 32, operand/result width (ALU is 32-bit; other values unsupported).
- OP_W, 4, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  OP_W  requester 0 ALU op.
- req1_a, req1_b  in  WIDTH  requester 1 operands.
- req1_op  in  OP_W  requester 1 ALU op.
- resp_valid  out  2  one-hot: result available for requester i.
- resp_ready  in  2  requester i consumes result.
- resp_s  out  WIDTH  registered ALU result.
- busy  out  1  response slot occupied.

Behaviour:
- ALU op encoding (internal ALU):
  - 0000 add; 1000 sub; 0001 sll by B[4:0]; 0010 slt signed; 0011 sltu.
  - 0100 xor; 0101 srl; 1101 sra; 0110 or; 0111 and.
  - Any other code yields 0. This is not an error.
- Slot state: EMPTY (busy=0) or FULL (busy=1, owner=0/1). Reset: EMPTY, resp_valid=2'b00, resp_s=0, req_ready=2'b00, rr pointer last=1 (requester 0 wins first tie).
- resp_valid[i] = FULL && owner==i. Registered; no combinational path from req_* to resp_*.
- drain = FULL && resp_ready[owner]. resp_ready of the non-owner is ignored.
- can_accept = EMPTY || drain.
- Grant (combinational, from req_valid and last):
  - Only one valid: grant it.
  - Both valid: grant the requester != last.
  - None valid: no grant.
- req_ready[i] = can_accept && grant[i]. At most one bit set. A request transfers when req_valid[i] && req_ready[i].
- On transfer:
  - Next cycle FULL, owner=i, resp_s = ALU(a_i, b_i, op_i) sampled at the transfer edge.
  - last = i.
  - Latency is exactly 1 cycle from transfer to resp_valid.
- Drain without transfer: next cycle EMPTY. resp_s holds its old value; don't-care.
- Drain with transfer in the same cycle: slot reloads back-to-back. Throughput is 1 op/cycle under continuous draining.
- FULL, no drain:
  - Slot and resp_s held stable.
  - req_ready=0.
  - last unchanged.
- Requesters must hold a_i/b_i/op_i stable while req_valid[i]=1 && !req_ready[i]. The block does not latch unaccepted requests.
- Starvation bound: a continuously valid requester is granted within 2 accepts.
- Async reset mid-operation: slot cleared immediately, any pending result lost, rr pointer back to last=1. Outputs return to reset values without waiting for clk.
- Release of rst_n is synchronous to clk externally. No accept occurs in the cycle rst_n is deasserted asynchronously relative to the edge.

Test Plan:
- Reset: rst_n=0 mid-FULL slot → resp_valid=00, busy=0, resp_s=0 immediately. After release, first tie grants requester 0.
- Single op: req0 a=5, b=7, op=0000 with resp_ready0=1 → req_ready=01. Next cycle resp_valid=01, resp_s=12, then EMPTY.
- Signed/unsigned: req1 a=0xFFFFFFFF, b=1, op=0010 → resp_s=1. op=0011 → resp_s=0. op=1101 with b=4 → 0xFFFFFFFF. op=1111 → 0.
- Round-robin: both valid continuously, resp_ready=11 → grants alternate 0,1,0,1. One result every cycle; owners match resp_valid.
- Backpressure: slot FULL owner 0, resp_ready0=0 for 3 cycles, resp_ready1=1 → resp_s stable, req_ready=00, busy=1. resp_ready0=1 drains and accepts the pending req1 the same cycle.
- Sub/shift wrap: a=0, b=1, op=1000 → 0xFFFFFFFF. a=1, b=33, op=0001 → 2 (only b[4:0] used).
